microfono_rx: RTL and testbench
===============================

# microfono_rx

I2S microphone receiver. Generates the bit clock and word-select for an external I2S MEMS microphone and deserialises one channel slot into 16-bit PCM samples. Samples are buffered in a 4-entry FIFO behind a valid/ready handshake. It is the capture stage upstream of the speaker transmitter, which takes each popped `sample_data` as its 16-bit input word.

## Interface
- `CLK_DIV`, 8: clk cycles per bclk half-period; legal range 4..255.
- `CHANNEL`, 0: slot captured; 0 = left (ws low), 1 = right (ws high).
- `clk`, input, 1: system clock; all logic on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `enable`, input, 1: runs clock generation and capture when high.
- `mic_sd`, input, 1: serial data from the microphone; asynchronous to clk.
- `bclk`, output, 1: I2S bit clock, registered.
- `ws`, output, 1: I2S word select (L/R clock), registered.
- `sample_data`, output, 16: head of FIFO, two's complement, MSB first as received.
- `sample_valid`, output, 1: FIFO not empty.
- `sample_ready`, input, 1: consumer pops the head when `valid & ready` at a clk edge.
- `fifo_level`, output, 3: entries held, 0..4.
- `overflow`, output, 1: sticky; set when a completed sample is dropped.

## Operation
- Reset values: `bclk`=0, `ws`=0, `sample_valid`=0, `sample_data`=0, `fifo_level`=0, `overflow`=0. Divider, bit counter, shift register and FIFO pointers are all 0.
- `mic_sd` passes through a 2-flop synchroniser; "sampled data" below means the synchroniser output.
- Divider: `div_cnt` counts 0..CLK_DIV-1 while `enable`=1. At `CLK_DIV-1` it wraps to 0 and `bclk` toggles.
  - Rise event: the edge where `bclk` goes 0→1.
  - Fall event: the edge where `bclk` goes 1→0.
- `bit_cnt` is 6 bits, 0..63, and increments with wrap on each fall event. On the same edge `ws` <= (new `bit_cnt` >= 32). A frame is 64 bclk: 32 left, then 32 right.
- Slot position `p = bit_cnt[4:0]`, `slot = bit_cnt[5]`.
- At a rise event with `slot==CHANNEL`:
  - p=0 is the I2S one-bit delay and is ignored.
  - p=1..16 shift sampled data into a 16-bit register, MSB first.
  - p=17..31 are ignored (the microphone's extra LSBs and padding).
- At the rise event with p=16, the word `{shift[14:0], sampled}` is pushed into the FIFO on that same edge.
- FIFO: 4 entries, circular. `sample_data` always shows the head entry and holds its value while `sample_valid`=0.
  - Pop occurs when `sample_valid & sample_ready`.
  - Push when full and no pop on that edge: the new word is discarded, `overflow` is set to 1, and the FIFO is unchanged.
  - Push and pop on the same edge while full: both take effect and `fifo_level` stays 4.
  - Push and pop on the same edge at other levels: both take effect and the level is unchanged.
  - `sample_ready` while empty has no effect.
- `enable` low:
  - Next edge: `div_cnt`, `bit_cnt` and the shift register clear; `bclk`=0 and `ws`=0; any partial word is discarded.
  - FIFO contents, popping and `overflow` are unaffected.
- `reset` overrides everything, including an in-progress push or pop, and clears `overflow`.

## Timing
- bclk period is 2·CLK_DIV clk cycles. A frame is 128·CLK_DIV clk cycles.
- Counting `enable` as first sampled high at edge 0:
  - bclk rise event k occurs at edge CLK_DIV·(2k+1).
  - The first ws high occurs at fall event 31, i.e. edge 64·CLK_DIV.
- CHANNEL=0:
  - First push at rise event 16, edge 33·CLK_DIV.
  - `sample_valid`=1 is visible in the cycle after that edge.
- CHANNEL=1: first push at rise event 48.
- Steady state: exactly one push per frame.
- Input timing: the microphone changes `mic_sd` after a bclk fall. The sampled value is the pin state 2 clk before the rise event. CLK_DIV ≥ 4 guarantees at least 2 clk of margin after the fall.
- Push-to-valid latency is 1 clk. A pop updates `sample_data` and `fifo_level` on the same edge.

## Test plan
- Basic capture:
  - Stimulus: CLK_DIV=4, CHANNEL=0, reset then enable. The mic model drives left = 0xA5C3 in bits 1..16 with 1s in bits 17..31, and right = 0x1234.
  - Required: `sample_data`=0xA5C3 with valid first high the cycle after edge 132; the right word never appears.
- Right channel:
  - Stimulus: CHANNEL=1 with the same stream.
  - Required: 0x1234 pushed at rise event 48, once per frame.
- Overflow:
  - Stimulus: `sample_ready`=0 for 5 frames.
  - Required: `fifo_level`=4 holding the first 4 words in order; `overflow`=1 after the 5th push. Then ready=1 pops the 4 words and `overflow` stays 1.
- Full with simultaneous push and pop:
  - Stimulus: level 4, and `sample_ready` asserted exactly on a push edge.
  - Required: level remains 4, no overflow, the oldest word is removed and the newest is appended.
- Enable drop mid-word:
  - Stimulus: drop `enable` at left-slot p=8, re-enable 10 clk later.
  - Required: `bclk`/`ws` are 0 the edge after the drop, no push occurs, and the next push is a complete word at 33·CLK_DIV after re-enable.
- Reset mid-operation:
  - Stimulus: assert `reset` for 1 clk with level 3 and `overflow`=1.
  - Required: all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/microfono_rx.sv
// rtl/microfono_rx.sv - I2S microphone receiver: bclk/ws generation, one-slot capture, 4-entry sample FIFO
module microfono_rx #(
  parameter int CLK_DIV = 8,
  parameter bit CHANNEL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mic_sd,
  output logic        bclk,
  output logic        ws,
  output logic [15:0] sample_data,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic [2:0]  fifo_level,
  output logic        overflow
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic        sd_meta;
  logic        sd_sync;
  logic        en_q;
  logic [7:0]  div_cnt;
  logic [5:0]  bit_cnt;
  logic [15:0] shift;
  logic [15:0] mem [4];
  logic [1:0]  rd_ptr;
  logic [1:0]  wr_ptr;

  logic        tick;
  logic        rise;
  logic        fall;
  logic [4:0]  pos;
  logic        in_slot;
  logic [5:0]  bit_cnt_next;
  logic        push;
  logic        pop;
  logic        full;
  logic        do_push;
  logic [15:0] word;

  // The edge where enable is first seen high only arms the divider, so rise k lands on CLK_DIV*(2k+1).
  assign tick         = enable && en_q && (div_cnt == DIV_LAST);
  assign rise         = tick && !bclk;
  assign fall         = tick && bclk;
  assign pos          = bit_cnt[4:0];
  assign in_slot      = (bit_cnt[5] == CHANNEL);
  assign bit_cnt_next = bit_cnt + 6'd1;
  assign word         = {shift[14:0], sd_sync};
  assign push         = rise && in_slot && (pos == 5'd16);
  assign pop          = sample_valid && sample_ready;
  assign full         = (fifo_level == 3'd4);
  assign do_push      = push && (!full || pop);

  assign sample_valid = (fifo_level != 3'd0);
  assign sample_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      sd_meta    <= 1'b0;
      sd_sync    <= 1'b0;
      en_q       <= 1'b0;
      div_cnt    <= 8'd0;
      bit_cnt    <= 6'd0;
      shift      <= 16'd0;
      bclk       <= 1'b0;
      ws         <= 1'b0;
      rd_ptr     <= 2'd0;
      wr_ptr     <= 2'd0;
      fifo_level <= 3'd0;
      overflow   <= 1'b0;
      for (int i = 0; i < 4; i++) mem[i] <= 16'd0;
    end else begin
      sd_meta <= mic_sd;
      sd_sync <= sd_meta;
      en_q    <= enable;

      if (!enable) begin
        div_cnt <= 8'd0;
        bit_cnt <= 6'd0;
        shift   <= 16'd0;
        bclk    <= 1'b0;
        ws      <= 1'b0;
      end else if (en_q) begin
        if (tick) begin
          div_cnt <= 8'd0;
          bclk    <= !bclk;
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
        if (fall) begin
          bit_cnt <= bit_cnt_next;
          ws      <= bit_cnt_next[5];
        end
        if (rise && in_slot && (pos >= 5'd1) && (pos <= 5'd16)) shift <= word;
      end

      // A push into a full FIFO survives only if the head leaves on the same edge.
      if (do_push) begin
        mem[wr_ptr] <= word;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (push && full && !pop) overflow <= 1'b1;
      if (pop) rd_ptr <= rd_ptr + 2'd1;

      case ({do_push, pop})
        2'b10:   fifo_level <= fifo_level + 3'd1;
        2'b01:   fifo_level <= fifo_level - 3'd1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

endmodule

// File: tb/tb_microfono_rx.sv
// tb/tb_microfono_rx.sv - randomized bench for microfono_rx, both channel variants against a frame-level model
module tb_microfono_rx;

  localparam int CD    = 4;
  localparam int FRAME = 128 * CD;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        mic_sd = 1'b0;
  logic        sample_ready;

  logic        bclk_w  [2];
  logic        ws_w    [2];
  logic [15:0] data_w  [2];
  logic        valid_w [2];
  logic [2:0]  lvl_w   [2];
  logic        ovf_w   [2];

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] words [256][2];
  int          run_base = 0;
  int          n = -1;
  int          mic_cnt = 0;
  logic        prev_bclk = 1'b0;

  logic [15:0] mq  [2][4];
  int          lvl [2];
  logic        ovf [2];
  logic        pop_m;
  logic        push_m;
  logic [15:0] w_m;

  always #5 clk = !clk;

  microfono_rx #(.CLK_DIV(CD), .CHANNEL(1'b0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .mic_sd(mic_sd),
    .bclk(bclk_w[0]), .ws(ws_w[0]), .sample_data(data_w[0]), .sample_valid(valid_w[0]),
    .sample_ready(sample_ready), .fifo_level(lvl_w[0]), .overflow(ovf_w[0])
  );

  microfono_rx #(.CLK_DIV(CD), .CHANNEL(1'b1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .mic_sd(mic_sd),
    .bclk(bclk_w[1]), .ws(ws_w[1]), .sample_data(data_w[1]), .sample_valid(valid_w[1]),
    .sample_ready(sample_ready), .fifo_level(lvl_w[1]), .overflow(ovf_w[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Edge nn after enable start is a capture edge for channel ch when it is bclk rise k, k%64 == 16+32*ch.
  function automatic bit is_push(input int nn, input int ch);
    if (nn <= 0 || nn % CD != 0 || (nn / CD) % 2 != 1) return 1'b0;
    return (((nn / CD - 1) / 2) % 64) == 16 + 32 * ch;
  endfunction

  function automatic logic mic_bit(input int cnt);
    int f, pp, p, s;
    logic [15:0] w;
    f  = cnt / 64;
    pp = cnt % 64;
    s  = pp / 32;
    p  = pp % 32;
    if (p == 0) return 1'b0;
    if (p > 16) return 1'b1;
    w = words[(run_base + f) % 256][s];
    return w[16 - p];
  endfunction

  always @(posedge clk) begin
    #1;
    if (reset) begin
      n = -1;
      for (int ch = 0; ch < 2; ch++) begin
        lvl[ch] = 0;
        ovf[ch] = 1'b0;
        for (int i = 0; i < 4; i++) mq[ch][i] = 16'd0;
      end
    end else begin
      n = enable ? n + 1 : -1;
      for (int ch = 0; ch < 2; ch++) begin
        pop_m  = (lvl[ch] > 0) && sample_ready;
        push_m = is_push(n, ch);
        w_m    = words[(run_base + ((n / CD - 1) / 2) / 64) % 256][ch];
        if (push_m && lvl[ch] == 4 && !pop_m) begin
          ovf[ch] = 1'b1;
        end else begin
          if (pop_m) begin
            for (int i = 0; i < 3; i++) mq[ch][i] = mq[ch][i + 1];
            lvl[ch]--;
          end
          if (push_m) begin
            mq[ch][lvl[ch]] = w_m;
            lvl[ch]++;
          end
        end
      end
    end

    for (int ch = 0; ch < 2; ch++) begin
      check($sformatf("bclk%0d", ch), 32'(bclk_w[ch]), (n >= 0) ? 32'((n / CD) % 2) : 32'd0);
      check($sformatf("ws%0d", ch), 32'(ws_w[ch]), (n >= 0) ? 32'((((n / CD) / 2) % 64) >= 32) : 32'd0);
      check($sformatf("level%0d", ch), 32'(lvl_w[ch]), 32'(lvl[ch]));
      check($sformatf("valid%0d", ch), 32'(valid_w[ch]), 32'(lvl[ch] > 0));
      check($sformatf("overflow%0d", ch), 32'(ovf_w[ch]), 32'(ovf[ch]));
      if (lvl[ch] > 0) check($sformatf("data%0d", ch), 32'(data_w[ch]), 32'(mq[ch][0]));
    end

    if (reset || !enable) mic_cnt = 0;
    else if (prev_bclk && !bclk_w[0]) mic_cnt++;
    prev_bclk = bclk_w[0];
    #1 mic_sd = mic_bit(mic_cnt);
  end

  task automatic wait_level(input int ch, input int target);
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (lvl[ch] == target) return;
      @(negedge clk);
    end
    check("wait_level timeout", 32'(lvl[ch]), 32'(target));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      words[i][0] = 16'($urandom);
      words[i][1] = 16'($urandom);
    end
    for (int i = 0; i < 4; i++) begin
      words[i][0] = 16'hA5C3;
      words[i][1] = 16'h1234;
    end

    reset = 1'b1;
    enable = 1'b0;
    sample_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_data", 32'(data_w[0]), 32'h0);
    check("rst_level", 32'(lvl_w[0]), 32'h0);
    check("rst_bclk", 32'(bclk_w[0]), 32'h0);

    // Basic capture: left word appears the cycle after edge 33*CD.
    enable = 1'b1;
    sample_ready = 1'b1;
    for (int i = 0; i < 2 * FRAME && n != 33 * CD; i++) @(negedge clk);
    check("first_valid", 32'(valid_w[0]), 32'h1);
    check("first_word", 32'(data_w[0]), 32'hA5C3);
    repeat (3 * FRAME) @(negedge clk);

    // Fill to 4, then pop exactly on a push edge.
    sample_ready = 1'b0;
    wait_level(0, 4);
    for (int i = 0; i < 2 * FRAME && !is_push(n + 1, 0); i++) @(negedge clk);
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    check("simul_level", 32'(lvl_w[0]), 32'd4);
    check("simul_ovf", 32'(ovf_w[0]), 32'd0);

    // Overflow after a fresh start with ready low for 5+ frames.
    reset = 1'b1;
    run_base = 16;
    @(negedge clk);
    reset = 1'b0;
    repeat (6 * FRAME) @(negedge clk);
    check("ovf_level", 32'(lvl_w[0]), 32'd4);
    check("ovf_set", 32'(ovf_w[0]), 32'd1);
    sample_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("ovf_drain_level", 32'(lvl_w[0]), 32'd0);
    check("ovf_sticky", 32'(ovf_w[0]), 32'd1);

    // Drop enable at left-slot p=8, re-enable 10 clk later.
    for (int i = 0; i < 2 * FRAME && !(n >= 0 && ((n / CD) / 2) % 64 == 8); i++) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("drop_bclk", 32'(bclk_w[0]), 32'd0);
    check("drop_ws", 32'(ws_w[0]), 32'd0);
    repeat (9) @(negedge clk);
    run_base = 32;
    enable = 1'b1;
    repeat (2 * FRAME + $urandom_range(0, 50)) @(negedge clk);

    // Reset with level 3 and overflow set.
    sample_ready = 1'b0;
    wait_level(0, 3);
    check("pre_reset_ovf", 32'(ovf_w[0]), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_level", 32'(lvl_w[0]), 32'd0);
    check("mid_rst_valid", 32'(valid_w[0]), 32'd0);
    check("mid_rst_data", 32'(data_w[0]), 32'd0);
    check("mid_rst_ovf", 32'(ovf_w[0]), 32'd0);
    check("mid_rst_bclk", 32'(bclk_w[0]), 32'd0);
    check("mid_rst_ws", 32'(ws_w[0]), 32'd0);
    sample_ready = 1'b1;
    repeat (FRAME) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
